// File: rtl/axis_packet_arbiter.sv
// Round-robin AXI-Stream packet arbiter: N_SRC 32-bit sources share one output,
// grant held from first beat through the TLAST handshake, with TDEST/TUSER framing.
module axis_packet_arbiter #(
  parameter int N_SRC     = 4,
  parameter int MAX_BEATS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      cfg_enable,
  input  logic [N_SRC-1:0]      s_tvalid,
  output logic [N_SRC-1:0]      s_tready,
  input  logic [N_SRC*32-1:0]   s_tdata,
  input  logic [N_SRC-1:0]      s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [31:0]           m_tdata,
  output logic                  m_tlast,
  output logic [7:0]            m_tdest,
  output logic [3:0]            m_tuser,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic [CNT_W-1:0]      beat_cnt,
  output logic [CNT_W-1:0]      pkt_done_cnt,
  output logic                  err_overlong
);

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_e;

  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       last_q, last_d;
  logic             first_q, first_d;
  logic [7:0]       dest_q, dest_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic             err_q, err_d;

  logic [N_SRC-1:0] req;
  logic             pick_found;
  logic [2:0]       pick_idx;
  int               cand;
  logic             sel_valid, sel_last;
  logic [31:0]      sel_data;

  assign req = s_tvalid & cfg_enable;

  // Cyclic priority search starting one past the last completed grant.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = int'(last_q) + k;
      if (cand >= N_SRC) cand = cand - N_SRC;
      for (int i = 0; i < N_SRC; i++) begin
        if (!pick_found && cand == i && req[i]) begin
          pick_found = 1'b1;
          pick_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == 3'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_data  = s_tdata[32*i +: 32];
      end
    end
  end

  // Handshake: a beat transfers on a rising edge where m_tvalid and m_tready are
  // both high; in PASS the granted source sees m_tready directly, so the stream
  // path is purely combinational with no added latency.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    first_d  = first_q;
    dest_d   = dest_q;
    beat_d   = beat_q;
    pkt_d    = pkt_q;
    err_d    = err_q;
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tdest  = '0;
    m_tuser  = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          first_d = 1'b1;
          beat_d  = '0;
          state_d = PASS;
        end
      end
      PASS: begin
        m_tvalid = sel_valid;
        m_tdata  = sel_data;
        m_tlast  = sel_last;
        m_tdest  = first_q ? sel_data[31:24] : dest_q;
        m_tuser  = {3'b000, first_q};
        for (int i = 0; i < N_SRC; i++) begin
          if (grant_q == 3'(i)) s_tready[i] = m_tready;
        end
        if (sel_valid && m_tready) begin
          first_d = 1'b0;
          if (first_q) dest_d = sel_data[31:24];
          if (beat_q != '1) beat_d = beat_q + CNT_ONE;
          if (beat_q == MAX_LIM) err_d = 1'b1;
          if (sel_last) begin
            last_d  = grant_q;
            pkt_d   = pkt_q + CNT_ONE;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 3'(N_SRC - 1);
      first_q <= 1'b0;
      dest_q  <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      first_q <= first_d;
      dest_q  <= dest_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q == PASS);
  assign grant_id     = grant_q;
  assign beat_cnt     = beat_q;
  assign pkt_done_cnt = pkt_q;
  assign err_overlong = err_q;

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Round-robin packet arbiter that shares one 32-bit AXI-Stream output among N_SRC packet sources.
- Grant is held for a whole packet, from the first beat through the TLAST handshake.
- Generates output framing: TDEST is taken from the first beat's data[31:24], and TUSER[0] marks the first beat.
- Sits between the capture/readout sources and the shared stream consumer (DMA/host link).

Parameters:
- N_SRC, 4, number of source ports (2..8).
- MAX_BEATS, 1024, packet length above which err_overlong is raised.
- CNT_W, 16, width of the per-grant beat counter and pkt_done_cnt.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_enable  in  N_SRC  per-source arbitration enable.
- s_tvalid  in  N_SRC  source valid.
- s_tready  out  N_SRC  source ready.
- s_tdata  in  N_SRC*32  source data; source i occupies [32*i+31:32*i].
- s_tlast  in  N_SRC  source end-of-packet.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  32  output data.
- m_tlast  out  1  output end-of-packet.
- m_tdest  out  8  packet destination.
- m_tuser  out  4  {3'b0, first_beat}.
- busy  out  1  high while in PASS.
- grant_id  out  3  index of the current or last granted source.
- beat_cnt  out  CNT_W  beats accepted in the current packet.
- pkt_done_cnt  out  CNT_W  completed packets, wraps.
- err_overlong  out  1  sticky overlong-packet flag; cleared only by reset.

Behaviour:
- Reset (asynchronous assert, synchronous deassert use):
  - State is IDLE.
  - All s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tdest=0, m_tuser=0.
  - busy=0, grant_id=0, beat_cnt=0, pkt_done_cnt=0, err_overlong=0.
  - Round-robin pointer last_grant = N_SRC-1, so source 0 has first priority.
- FSM states: IDLE and PASS.
- IDLE:
  - req = s_tvalid & cfg_enable.
  - If req != 0: pick the first set bit searching upward (cyclically) from last_grant+1, register it as grant_id, set first=1, beat_cnt=0, and go to PASS on the next edge.
  - This gives a 1-cycle arbitration bubble; no s_tready is asserted in IDLE.
- PASS, with g = grant_id:
  - Output path: m_tvalid = s_tvalid[g], m_tdata = s_tdata[g], m_tlast = s_tlast[g].
  - Ready path: s_tready[g] = m_tready; all other s_tready = 0.
  - This path is combinational: zero latency, full throughput.
- m_tdest:
  - While first=1: m_tdest = s_tdata[g][31:24] (combinational).
  - On the first handshake, data[31:24] is latched into dest_q; m_tdest = dest_q for all later beats of the packet.
- m_tuser = {3'b0, first}; first clears on the first handshake (m_tvalid & m_tready).
- beat_cnt increments on each handshake and saturates at all-ones.
- If a handshake occurs with beat_cnt == MAX_BEATS (i.e. beat MAX_BEATS+1), err_overlong is set; the packet is still passed through unchanged.
- Handshake with m_tlast=1:
  - last_grant = g, pkt_done_cnt += 1 (mod 2^CNT_W), return to IDLE.
  - The next grant follows after the 1-cycle bubble.
- Single-beat packet: first=1 and m_tlast=1 on the same beat; m_tuser=4'b0001, m_tlast=1, m_tdest = data[31:24].
- Valid and data stability:
  - When s_tvalid drops mid-packet, m_tvalid drops and the grant is held with no timeout.
  - Sources must hold data stable while valid and not ready; the arbiter does not check this.
- cfg_enable:
  - Sampled only in IDLE.
  - Clearing it for the granted source mid-packet has no effect until TLAST.
- grant_id and busy are registered; busy = (state == PASS).
- Reset asserted mid-packet: immediate return to the reset values. The partial packet is dropped from the arbiter's view, and the source is responsible for re-framing.

Test Plan:
- Sources 0 and 2 each present a 3-beat packet simultaneously, m_tready=1 → source 0 first, 1 bubble cycle, then source 2; m_tuser=1 only on the beat after each grant; m_tdest equals bits [31:24] of each first word; pkt_done_cnt=2.
- All 4 sources continuously offer 1-beat packets → grant order 0,1,2,3,0…; one packet every 2 cycles; each beat has m_tlast=1 and m_tuser=4'b0001.
- Source 1 packet of 5 beats with m_tready toggling 1,0,1,0 → data unchanged while stalled, exactly 5 handshakes, m_tdest constant, beat_cnt=5 before returning to IDLE.
- cfg_enable=4'b1101 with all sources valid → source 1 is never granted; clearing cfg_enable[0] mid-packet still completes source 0's packet.
- MAX_BEATS=4, 6-beat packet → err_overlong rises on the 5th handshake and stays high after the packet ends until rst_n goes low.
- rst_n pulsed low during beat 2 of a 4-beat packet → all outputs return to 0 asynchronously; after release, source 0 is granted first.
